// File: rtl/grid_mem_slave.sv
// grid_mem_slave: Avalon-MM responder that backs the falling-sand cell grid.
// Answers single-word reads and writes from an on-chip 16-bit word array,
// zero-fills the array after reset, returns read data after a fixed
// pipelined latency and inserts wait states after every accepted write.
module grid_mem_slave #(
    parameter int DEPTH          = 38400,  // 80 words/row x 480 rows
    parameter int READ_LATENCY   = 1,      // 1..4
    parameter int WRITE_RECOVERY = 1       // 0..3
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [23:0] mem_address,
    input  logic        mem_read,
    input  logic        mem_write,
    input  logic [15:0] mem_writedata,
    output logic        mem_waitrequest,
    output logic        mem_readdatavalid,
    output logic [15:0] mem_readdata,
    output logic        init_done,
    output logic        err
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    localparam logic [1:0] ST_CLEAR    = 2'd0;
    localparam logic [1:0] ST_IDLE     = 2'd1;
    localparam logic [1:0] ST_WRECOVER = 2'd2;

    logic [1:0]    state;
    logic [AW-1:0] clr_ptr;
    logic [1:0]    wr_cnt;
    logic [15:0]   mem [DEPTH];

    logic          idle;
    logic          in_range;
    logic          wr_acc;
    logic          rd_acc;
    logic [AW-1:0] addr_idx;
    logic          ram_we;
    logic [AW-1:0] ram_addr;
    logic [15:0]   ram_wdata;
    logic [15:0]   rd_word;

    // Read pipeline: stage 0 loads at the acceptance edge, the last stage drives the outputs.
    logic          pipe_vld [READ_LATENCY];
    logic [15:0]   pipe_dat [READ_LATENCY];

    // Only IDLE accepts requests; waitrequest is a pure state decode so no
    // combinational path exists from the request inputs back to the master.
    assign idle            = (state == ST_IDLE);
    assign mem_waitrequest = !idle;
    assign init_done       = (state != ST_CLEAR);

    // The full 24-bit address is compared, so aliases above DEPTH are rejected.
    assign in_range = (mem_address < 24'(DEPTH));
    assign addr_idx = mem_address[AW-1:0];

    // Read+write together is treated as a write only.
    assign wr_acc = idle && !reset && mem_write;
    assign rd_acc = idle && !reset && mem_read && !mem_write;

    // One write port shared by the zero-fill sweep and accepted in-range writes.
    assign ram_we    = !reset && ((state == ST_CLEAR) || (wr_acc && in_range));
    assign ram_addr  = (state == ST_CLEAR) ? clr_ptr : addr_idx;
    assign ram_wdata = (state == ST_CLEAR) ? 16'h0000 : mem_writedata;

    // Out-of-range reads still answer, with zero data.
    assign rd_word = in_range ? mem[addr_idx] : 16'h0000;

    // Word array write port.
    // NOTE: the array itself has no reset; the CLEAR sweep zeroes it, which keeps it mappable onto block RAM.
    always_ff @(posedge clock) begin
        if (ram_we) begin
            mem[ram_addr] <= ram_wdata;
        end
    end

    // Control FSM: zero-fill sweep, idle service, write-recovery wait states.
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clock) begin
        if (reset) begin
            state   <= ST_CLEAR;
            clr_ptr <= '0;
            wr_cnt  <= '0;
        end else begin
            case (state)
                ST_CLEAR: begin
                    if (clr_ptr == AW'(DEPTH - 1)) begin
                        state <= ST_IDLE;
                    end else begin
                        clr_ptr <= clr_ptr + AW'(1);
                    end
                end
                ST_IDLE: begin
                    if (wr_acc && (WRITE_RECOVERY != 0)) begin
                        state  <= ST_WRECOVER;
                        wr_cnt <= 2'(WRITE_RECOVERY - 1);
                    end
                end
                ST_WRECOVER: begin
                    if (wr_cnt == 2'd0) begin
                        state <= ST_IDLE;
                    end else begin
                        wr_cnt <= wr_cnt - 2'd1;
                    end
                end
                default: begin
                    state <= ST_CLEAR;
                end
            endcase
        end
    end

    // Sticky error: out-of-range access or simultaneous read+write.
    always_ff @(posedge clock) begin
        if (reset) begin
            err <= 1'b0;
        end else if ((wr_acc && (!in_range || mem_read)) || (rd_acc && !in_range)) begin
            err <= 1'b1;
        end
    end

    // Read pipeline shift; data stages only move with a valid so the output holds its last value.
    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < READ_LATENCY; i++) begin
                pipe_vld[i] <= 1'b0;
                pipe_dat[i] <= 16'h0000;
            end
        end else begin
            pipe_vld[0] <= rd_acc;
            if (rd_acc) begin
                pipe_dat[0] <= rd_word;
            end
            for (int i = 1; i < READ_LATENCY; i++) begin
                pipe_vld[i] <= pipe_vld[i-1];
                if (pipe_vld[i-1]) begin
                    pipe_dat[i] <= pipe_dat[i-1];
                end
            end
        end
    end

    assign mem_readdatavalid = pipe_vld[READ_LATENCY-1];
    assign mem_readdata      = pipe_dat[READ_LATENCY-1];

endmodule

// File: doc/grid_mem_slave.md
# grid_mem_slave

Avalon-MM responder that backs the falling-sand cell grid: it answers the physics engine's SDRAM-master requests (single-word reads and writes on `mem_*`) from an on-chip 16-bit word array. It zero-fills the grid after reset, applies a fixed pipelined read latency, and inserts write-recovery wait states. It is the simulation and bring-up stand-in for the SDRAM controller, pin-compatible with the master side of the sand engine.

## Interface
- `DEPTH`, 38400: number of 16-bit grid words; 80 words per row × 480 rows.
- `READ_LATENCY`, 1: edges from read acceptance to data valid; legal range 1..4.
- `WRITE_RECOVERY`, 1: wait-state cycles after each accepted write; legal range 0..3.
- `clock` in 1: sole clock; all logic on its rising edge.
- `reset` in 1: synchronous, active-high.
- `mem_address` in 24: word address.
- `mem_read` in 1: read request.
- `mem_write` in 1: write request.
- `mem_writedata` in 16: write payload.
- `mem_waitrequest` out 1: high = request not accepted this cycle.
- `mem_readdatavalid` out 1: one-cycle pulse per accepted read.
- `mem_readdata` out 16: read data, meaningful only while `mem_readdatavalid` is high.
- `init_done` out 1: high once the zero-fill has completed.
- `err` out 1: sticky error flag, cleared only by reset.

## Operation
- Acceptance: a request is accepted at a rising edge where (`mem_read` | `mem_write`) = 1 and `mem_waitrequest` = 0.
- State machine:
  - CLEAR (entered on reset): writes 0 to address `clr_ptr`; `clr_ptr` runs 0..DEPTH-1, one word per cycle. After the write to DEPTH-1 → IDLE, and `init_done` goes to 1. `mem_waitrequest` = 1 throughout.
  - IDLE: `mem_waitrequest` = 0.
    - Accepted write: `mem[addr] <= mem_writedata` at the acceptance edge. Then → WRECOVER if WRITE_RECOVERY > 0, else stay in IDLE.
    - Accepted read: enters the read pipeline; stay in IDLE, so back-to-back reads are accepted every cycle.
  - WRECOVER: `mem_waitrequest` = 1 for exactly WRITE_RECOVERY cycles, counted by `wr_cnt`, then → IDLE.
- `mem_waitrequest` is a pure decode of state, with no combinational path from inputs.
- Address range: `mem_address` >= DEPTH (compare on all 24 bits) is out of range.
  - Out-of-range write: dropped, no array change; sets `err`.
  - Out-of-range read: still produces a `mem_readdatavalid` pulse with `mem_readdata` = 16'h0000; sets `err`.
- Simultaneous `mem_read` and `mem_write` in an accepted cycle: treated as a write only. No `mem_readdatavalid` is produced; sets `err`.
- Read data is the array content at the acceptance edge, so a write in the same cycle is never visible to that read.
- Read-after-write to the same address in later cycles returns the new data.
- `mem_readdata` holds its last value when `mem_readdatavalid` is low.
- Requests presented while `mem_waitrequest` = 1 are ignored (no array change, no error). The master must hold them.

## Timing
- Reset values (first edge with `reset` = 1 and every edge thereafter while it stays high):
  - `mem_waitrequest` = 1, `mem_readdatavalid` = 0, `mem_readdata` = 0, `init_done` = 0, `err` = 0.
  - state = CLEAR, `clr_ptr` = 0, read pipeline flushed.
- Zero-fill: first IDLE cycle (`mem_waitrequest` = 0, `init_done` = 1) occurs DEPTH edges after the edge on which `reset` is sampled low.
- Read latency: for a read accepted at edge n, `mem_readdatavalid` = 1 and `mem_readdata` are valid for the period between edge n+L-1 and edge n+L, where L = READ_LATENCY. The master samples them at edge n+L.
- With L = 1, a master that pulses read for one cycle and samples two edges after raising it sees valid data.
- Read pipeline: L stages of {valid, data}; a new read is accepted every cycle. Order is preserved, one pulse per read.
- Write: accepted at edge n. `mem_waitrequest` is high for the periods after edges n..n+WRITE_RECOVERY-1, and low again after edge n+WRITE_RECOVERY.
- Mid-operation reset: reads in flight are discarded, with no `mem_readdatavalid` after the reset edge. A zero-fill in progress restarts from address 0. Array contents are re-zeroed by the new CLEAR.
- `err` sets on the edge after the offending acceptance edge's evaluation, i.e. visible the cycle after acceptance.

## Test plan
- Run with DEPTH=16, READ_LATENCY=1, WRITE_RECOVERY=1. Release reset, then after 16 edges read addresses 0..15 → every word reads 16'h0000, `init_done` = 1, `mem_waitrequest` low from edge 16.
- Write 16'hA5C3 to address 5; `mem_waitrequest` is 1 for one cycle after the write. Then read address 5 → `mem_readdatavalid` for exactly one cycle, 1 edge after acceptance, with `mem_readdata` = 16'hA5C3.
- With READ_LATENCY=3, issue back-to-back reads of addresses 1, 2, 3 holding data 16'h0001/0002/0003 → three consecutive valid pulses starting 3 edges after the first acceptance, in order 1, 2, 3.
- Read address 16 (out of range), then write address 24'hFFFFFF → the read returns 16'h0000 with valid, the write changes no word, and `err` = 1 and stays 1 until reset.
- Assert read+write together on address 7 with data 16'h1234 → word 7 = 16'h1234, no `mem_readdatavalid`, `err` = 1. Hold a write to address 8 during a WRECOVER cycle → accepted only once `mem_waitrequest` drops.
- Assert reset at clr_ptr=9, and separately with a read in flight at READ_LATENCY=2 → no `mem_readdatavalid` after the reset edge, and after release the zero-fill takes the full 16 cycles again with all words reading 0.
